// File: rtl/iter_sequencer_pkg.sv
// Shared definitions for the iteration sequencer: FSM state encoding and run-mode constants.
package iter_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_ONESHOT = 0;
    localparam int MODE_WRAP    = 1;

endpackage

// File: rtl/iter_sequencer_up_counter.sv
// Ripple-enable up counter built from toggle cells; a synchronous clear wins over counting.
module t_flip_flop (
    input  logic clk,
    input  logic clr,
    input  logic t,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every cell samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

module up_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Bit i toggles when counting is enabled and every lower bit is already 1.
    logic [WIDTH-1:0] toggle;

    assign toggle[0] = en;

    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign toggle[i] = toggle[i-1] & count[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_flip_flop u_tff (
            .clk (clk),
            .clr (clr),
            .t   (toggle[i]),
            .q   (count[i])
        );
    end

endmodule

// File: rtl/iter_sequencer.sv
// Iteration sequencer: runs an index from 0 to a latched terminal count, one-shot or auto-restart.
module iter_sequencer
    import iter_sequencer_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int LAST  = 32,
    parameter int MODE  = MODE_ONESHOT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             ready,
    output logic             first,
    output logic             last,
    output logic             done
);

    localparam logic [WIDTH-1:0] LAST_TERM = WIDTH'(LAST);
    localparam bit               WRAP      = (MODE == MODE_WRAP);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] term_nxt;
    logic             wrap_done;
    logic             wrap_done_nxt;
    logic             cnt_clr;
    logic             cnt_en;
    logic             at_term;

    up_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    assign at_term = (count == term);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt     = state;
        term_nxt      = term;
        wrap_done_nxt = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    term_nxt  = (limit == '0) ? LAST_TERM : limit;
                    cnt_clr   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (enable) begin
                    if (!at_term) begin
                        cnt_en = 1'b1;
                    end else if (WRAP) begin
                        cnt_clr       = 1'b1;
                        wrap_done_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Reset also zeroes the counter through its synchronous clear.
        if (reset) begin
            cnt_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            term      <= LAST_TERM;
            wrap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            term      <= term_nxt;
            wrap_done <= wrap_done_nxt;
        end
    end

    // All outputs decode registered state and count only.
    assign busy  = (state == RUN);
    assign ready = (state == IDLE) || (state == DONE);
    assign first = busy && (count == '0);
    assign last  = busy && at_term;
    assign done  = (state == DONE) || wrap_done;

endmodule

// File: tb/tb_iter_sequencer.sv
// Self-checking bench: three sequencer configurations share stimulus and are compared to behavioural models.
module tb_iter_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       enable = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] limit = 6'd0;

    logic [5:0] count_a, count_w;
    logic [3:0] count_n;
    logic busy_a, ready_a, first_a, last_a, done_a;
    logic busy_w, ready_w, first_w, last_w, done_w;
    logic busy_n, ready_n, first_n, last_n, done_n;
    logic [31:0] out_a, out_w, out_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int st;
        int cnt;
        int term;
        bit wrapf;
    } mdl_t;

    mdl_t ma, mw, mn;

    typedef struct {
        int rs, st, en, ab, lim;
        int cnt, busy, ready, first, last, done;
    } vec_t;

    always #5 clk = ~clk;

    iter_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort), .limit(limit),
        .count(count_a), .busy(busy_a), .ready(ready_a), .first(first_a), .last(last_a), .done(done_a)
    );

    iter_sequencer #(.WIDTH(6), .LAST(32), .MODE(1)) dut_w (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort), .limit(limit),
        .count(count_w), .busy(busy_w), .ready(ready_w), .first(first_w), .last(last_w), .done(done_w)
    );

    iter_sequencer #(.WIDTH(4), .LAST(10), .MODE(0)) dut_n (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort), .limit(limit[3:0]),
        .count(count_n), .busy(busy_n), .ready(ready_n), .first(first_n), .last(last_n), .done(done_n)
    );

    assign out_a = {19'd0, 2'b0, count_a, busy_a, ready_a, first_a, last_a, done_a};
    assign out_w = {19'd0, 2'b0, count_w, busy_w, ready_w, first_w, last_w, done_w};
    assign out_n = {19'd0, 4'b0, count_n, busy_n, ready_n, first_n, last_n, done_n};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next model state from the behavioural rules of the sequencer.
    function automatic mdl_t step(input mdl_t m, input int w, input int lst, input int md,
                                  input bit rs, input bit st, input bit en, input bit ab, input int lim);
        mdl_t n;
        int   l;
        n = m;
        l = lim % (1 << w);
        n.wrapf = 1'b0;
        if (rs) begin
            n.st = M_IDLE;
            n.cnt = 0;
            n.term = lst;
        end else if (m.st != M_RUN) begin
            if (st) begin
                n.st = M_RUN;
                n.cnt = 0;
                n.term = (l == 0) ? lst : l;
            end else begin
                n.st = M_IDLE;
            end
        end else if (ab) begin
            n.st = M_IDLE;
            n.cnt = 0;
        end else if (en) begin
            if (m.cnt < m.term) begin
                n.cnt = m.cnt + 1;
            end else if (md == 1) begin
                n.cnt = 0;
                n.wrapf = 1'b1;
            end else begin
                n.st = M_DONE;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] expect_out(input mdl_t m);
        int b;
        b = (m.st == M_RUN) ? 1 : 0;
        return 32'((m.cnt << 5) | (b << 4) | ((1 - b) << 3) | ((b != 0 && m.cnt == 0) << 2)
                   | ((b != 0 && m.cnt == m.term) << 1) | (m.st == M_DONE || m.wrapf));
    endfunction

    task automatic tick();
        @(posedge clk);
        ma = step(ma, 6, 32, 0, reset, start, enable, abort, int'(limit));
        mw = step(mw, 6, 32, 1, reset, start, enable, abort, int'(limit));
        mn = step(mn, 4, 10, 0, reset, start, enable, abort, int'(limit));
        @(negedge clk);
        check("model_oneshot", out_a, expect_out(ma));
        check("model_wrap", out_w, expect_out(mw));
        check("model_w4", out_n, expect_out(mn));
    endtask

    task automatic cyc(input bit rs, input bit st, input bit en, input bit ab, input int lim);
        reset  = rs;
        start  = st;
        enable = en;
        abort  = ab;
        limit  = 6'(lim);
        tick();
    endtask

    initial begin
        vec_t vt[14];
        int   busy_cyc, dones, drops, pulses;
        int   hist[6];
        logic done_seen;

        ma = '{M_IDLE, 0, 32, 1'b0};
        mw = '{M_IDLE, 0, 32, 1'b0};
        mn = '{M_IDLE, 0, 10, 1'b0};

        // Table: short run with hold, ignored start, done, abort, abort-beats-terminal.
        vt[0]  = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        vt[1]  = '{0, 1, 1, 0, 2,  0, 1, 0, 1, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 2,  1, 1, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 1, 0, 2,  2, 1, 0, 0, 1, 0};
        vt[5]  = '{0, 1, 1, 0, 2,  2, 0, 1, 0, 0, 1};
        vt[6]  = '{0, 0, 0, 0, 2,  2, 0, 1, 0, 0, 0};
        vt[7]  = '{0, 1, 0, 0, 0,  0, 1, 0, 1, 0, 0};
        vt[8]  = '{0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 0};
        vt[9]  = '{0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0};
        vt[10] = '{0, 1, 0, 0, 1,  0, 1, 0, 1, 0, 0};
        vt[11] = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 1, 0};
        vt[12] = '{0, 0, 1, 1, 1,  0, 0, 1, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].rs[0], vt[i].st[0], vt[i].en[0], vt[i].ab[0], vt[i].lim);
            check($sformatf("table_%0d", i), out_a,
                  32'((vt[i].cnt << 5) | (vt[i].busy << 4) | (vt[i].ready << 3)
                      | (vt[i].first << 2) | (vt[i].last << 1) | vt[i].done));
        end

        // Default terminal (limit 0 selects 32), enable held high.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check("r33_first", {first_a, count_a}, {1'b1, 6'd0});
        for (int k = 1; k <= 32; k++) begin
            cyc(0, 0, 1, 0, 0);
            check("r33_cnt", count_a, k);
            check("r33_last", last_a, (k == 32));
        end
        cyc(0, 0, 1, 0, 0);
        check("r33_done", {done_a, busy_a, count_a}, {1'b1, 1'b0, 6'd32});
        cyc(0, 0, 1, 0, 0);
        check("r33_idle_hold", {done_a, ready_a, count_a}, {1'b0, 1'b1, 6'd32});

        // Enable toggling: every value held two cycles, 12 busy cycles, one done.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 5);
        busy_cyc = 0;
        dones = 0;
        for (int v = 0; v < 6; v++) hist[v] = 0;
        busy_cyc += int'(busy_a);
        hist[0] += 1;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, (i % 2) == 1, 0, 5);
            busy_cyc += int'(busy_a);
            dones += int'(done_a);
            if (busy_a && count_a < 6) hist[count_a] += 1;
        end
        check("r34_busy_cycles", busy_cyc, 12);
        check("r34_dones", dones, 1);
        for (int v = 0; v < 6; v++) check($sformatf("r34_hold_%0d", v), hist[v], 2);

        // Abort at count 3.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 7);
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 7);
            done_seen |= done_a;
        end
        check("r35_at3", count_a, 3);
        cyc(0, 0, 1, 1, 7);
        check("r35_abort", {busy_a, ready_a, done_a, count_a}, {1'b0, 1'b1, 1'b0, 6'd0});
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 7);
            done_seen |= done_a;
        end
        check("r35_no_done", done_seen, 1'b0);

        // Auto-restart: 0,1,2,3,0,... with a done pulse per wrap, busy throughout.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 3);
        check("r36_start", {busy_w, count_w}, {1'b1, 6'd0});
        drops = 0;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 1, 0, 3);
            check("r36_cnt", count_w, i % 4);
            drops += int'(!busy_w);
            pulses += int'(done_w);
        end
        check("r36_pulses", pulses, 3);
        check("r36_busy_drops", drops, 0);

        // Start held high through DONE: back-to-back run with no IDLE cycle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2);
        cyc(0, 1, 1, 0, 2);
        cyc(0, 1, 1, 0, 2);
        check("r37_term", {last_a, count_a}, {1'b1, 6'd2});
        cyc(0, 1, 1, 0, 2);
        check("r37_done", {done_a, busy_a}, 2'b10);
        cyc(0, 1, 1, 0, 2);
        check("r37_rerun", {busy_a, first_a, done_a, count_a}, {1'b1, 1'b1, 1'b0, 6'd0});

        // WIDTH=4, term 15: reset at count 9, then a full run to the top value.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 15);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 15);
        check("r38_at9", count_n, 9);
        cyc(1, 1, 1, 1, 15);
        check("r38_reset", out_n, 32'h8);
        cyc(0, 0, 0, 0, 15);
        check("r38_no_done", {done_n, ready_n}, 2'b01);
        cyc(0, 1, 1, 0, 15);
        for (int k = 1; k <= 15; k++) cyc(0, 0, 1, 0, 15);
        check("r27_top", {last_n, count_n}, {1'b1, 4'd15});
        cyc(0, 0, 1, 0, 15);
        check("r27_done", {done_n, count_n}, {1'b1, 4'd15});
        cyc(0, 0, 1, 0, 15);
        check("r27_idle", {done_n, ready_n, count_n}, {1'b0, 1'b1, 4'd15});

        // Randomized traffic against the models.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0,
                $urandom_range(31) == 0,
                ($urandom_range(1) == 1) ? int'($urandom_range(6)) : int'($urandom_range(63)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
